segasys1_romload_dispatch: RTL and testbench
============================================

Name: segasys1_romload_dispatch

Overview:
- Parametrised successor to the single-bus ROM download fan-out in the System 1 top level.
- Receives the byte-wide ROMCL/ROMAD/ROMDT/ROMEN download stream and decodes it into NREG address windows.
- Packs bytes into DW-bit little-endian words with byte masks and buffers them in a FIFO.
- Issues valid/ready writes to the target memories, so video, sound and main ROM stores can be wide or slow.

Parameters:
- NREG, 4: number of target regions.
- AW, 25: download address width.
- DW, 16: target word width; a multiple of 8, with BPW = DW/8 a power of two and ≥ 1.
- FIFO_D, 4: word FIFO depth; a power of two and ≥ 2.
- REG_BASE, all 0: flat NREG*AW vector; the region i base is at bits [i*AW +: AW].
- REG_LIMIT, all 0: flat NREG*AW vector; the region i inclusive last byte address.

Ports:
- CLK48M, in, 1: system clock.
- RESETn, in, 1: asynchronous active-low reset.
- ROMCL, in, 1: download-active level.
- ROMAD, in, AW: byte address.
- ROMDT, in, 8: byte data.
- ROMEN, in, 1: byte strobe; one byte per cycle while high.
- WR_VALID, out, 1: write word available.
- WR_READY, in, 1: target accepts the word.
- WR_REG, out, NREG: one-hot target region.
- WR_ADDR, out, AW: local word address, (ROMAD-base) >> log2(BPW).
- WR_DATA, out, DW: packed word; lane k is bits [8k+7:8k].
- WR_MASK, out, BPW: byte enables.
- BUSY, out, 1: state is LOAD or DRAIN.
- DONE, out, 1: download completely delivered.
- OVF, out, 1: sticky flag; a word was dropped because the FIFO was full.
- UNMAP_CNT, out, 8: saturating count of bytes that fell in no region.

Behaviour:
- Reset, asynchronous on RESETn low:
  - All outputs are 0; state is IDLE.
  - FIFO is emptied, packer cleared, counters cleared.
  - Reset mid-download discards all pending data; no write is emitted afterwards until new bytes arrive.
- Region decode:
  - A byte hits region i when REG_BASE[i] ≤ ROMAD ≤ REG_LIMIT[i].
  - If regions overlap, the lowest index wins.
  - A byte that hits no region is discarded, UNMAP_CNT increments (saturating at 255), and the packer is not flushed.
- Packer: holds {region, word address, data, mask}.
  - An accepted byte writes lane ROMAD[log2(BPW)-1:0] and sets that mask bit.
  - A later byte to the same lane overwrites it.
- Flush conditions (the packer word is pushed to the FIFO):
  - (a) The accepted byte sets the last mask lane with full mask; push happens that cycle and the packer clears.
  - (b) A new mapped byte has a different region or word address than a non-empty packer; the old word is pushed and the new byte opens a fresh packer in the same cycle.
  - (c) ROMCL falls while the packer is non-empty. If ROMEN is coincident with the fall, that byte is merged first, then flushed.
- FIFO:
  - Registered push; WR_VALID rises the cycle after the push.
  - Pop occurs when WR_VALID and WR_READY are both high.
  - Output fields are stable while WR_VALID is high and WR_READY is low.
  - Push and pop may occur in the same cycle, including when full; a simultaneous pop frees the slot, so no drop occurs.
  - A push to a full FIFO with no pop drops the word and sets OVF.
  - Order is preserved.
- State machine:
  - IDLE → LOAD on ROMCL rising. On entry to LOAD, OVF, DONE and UNMAP_CNT clear.
  - LOAD → DRAIN on ROMCL falling.
  - DRAIN → DONE when the packer is empty and the FIFO is empty.
  - DONE → LOAD on ROMCL rising.
  - ROMCL rising during DRAIN → LOAD; pending words are still delivered.
- ROMEN while ROMCL is low is ignored.
- DONE is high only in state DONE. BUSY is high in LOAD and DRAIN.

Test Plan (NREG=2, DW=16, FIFO_D=4; region 0 = 0x0000–0x7FFF, region 1 = 0x8000–0xBFFF):
1. ROMCL=1, bytes 0x12@0x0000 then 0x34@0x0001, WR_READY=1 → one cycle after the second strobe: WR_VALID=1, WR_REG=01, WR_ADDR=0, WR_DATA=0x3412, WR_MASK=11; exactly one write.
2. 0xAA@0x8003, then 0x55@0x8010, then ROMCL falls → first write: WR_REG=10, ADDR=1, DATA=0xAA00, MASK=10. Second write: ADDR=8, DATA=0x0055, MASK=01. Then DONE=1, BUSY=0.
3. Byte @0xC000 → no write; UNMAP_CNT=1. After 300 such bytes, UNMAP_CNT=255.
4. WR_READY=0, six full words to region 0 → FIFO holds four words, OVF=1. WR_READY=1 and ROMCL falls → four writes in address order, then DONE=1, OVF still 1.
5. 0x11@0x7FFF then 0x22@0x8000 → two writes: {REG=01, ADDR=0x3FFF, DATA=0x1100, MASK=10} then {REG=10, ADDR=0, DATA=0x0022, MASK=01}.
6. Three words queued with WR_READY=0, then RESETn pulsed low → all outputs 0 asynchronously. After release with WR_READY=1, no write ever appears.

Source files
------------

// File: rtl/segasys1_romload_dispatch.sv
// ROM download fan-out: decodes the byte stream into address windows, packs bytes into
// little-endian words with byte masks, and delivers them through a small FIFO as valid/ready writes.
module segasys1_romload_dispatch #(
    parameter int                   NREG      = 4,
    parameter int                   AW        = 25,
    parameter int                   DW        = 16,
    parameter int                   FIFO_D    = 4,
    parameter logic [NREG*AW-1:0]   REG_BASE  = '0,
    parameter logic [NREG*AW-1:0]   REG_LIMIT = '0
) (
    input  logic              CLK48M,
    input  logic              RESETn,
    input  logic              ROMCL,
    input  logic [AW-1:0]     ROMAD,
    input  logic [7:0]        ROMDT,
    input  logic              ROMEN,
    output logic              WR_VALID,
    input  logic              WR_READY,
    output logic [NREG-1:0]   WR_REG,
    output logic [AW-1:0]     WR_ADDR,
    output logic [DW-1:0]     WR_DATA,
    output logic [DW/8-1:0]   WR_MASK,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVF,
    output logic [7:0]        UNMAP_CNT
);
    localparam int BPW = DW / 8;
    localparam int LB  = $clog2(BPW);
    localparam int LW  = (LB > 0) ? LB : 1;
    localparam int PW  = $clog2(FIFO_D);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state_q, state_d;
    logic              romcl_q;
    logic              ovf_q, ovf_d;
    logic [7:0]        unm_q, unm_d;

    logic [NREG-1:0]   pk_reg_q, pk_reg_d;
    logic [AW-1:0]     pk_addr_q, pk_addr_d;
    logic [DW-1:0]     pk_data_q, pk_data_d;
    logic [BPW-1:0]    pk_mask_q, pk_mask_d;

    logic [NREG-1:0]   f_reg_q  [FIFO_D];
    logic [AW-1:0]     f_addr_q [FIFO_D];
    logic [DW-1:0]     f_data_q [FIFO_D];
    logic [BPW-1:0]    f_mask_q [FIFO_D];
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              rise, fall, accept, hit, mapped, unmapped, pk_empty;
    logic [NREG-1:0]   hit_reg;
    logic [AW-1:0]     hit_base, byte_wa;
    logic [LW-1:0]     lane;
    logic [BPW-1:0]    byte_mask, m_mask;
    logic [DW-1:0]     m_data;
    logic              push, pop, full, wr_en, drop, enter_load;
    logic [NREG-1:0]   push_reg;
    logic [AW-1:0]     push_addr;
    logic [DW-1:0]     push_data;
    logic [BPW-1:0]    push_mask;

    // A byte coincident with the ROMCL fall is still taken, so it merges before the final flush.
    assign rise     = ROMCL & ~romcl_q;
    assign fall     = ~ROMCL & romcl_q;
    assign accept   = ROMEN & (ROMCL | romcl_q);
    assign pk_empty = (pk_mask_q == '0);

    always_comb begin
        hit_reg  = '0;
        hit_base = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (ROMAD >= REG_BASE[i*AW +: AW] && ROMAD <= REG_LIMIT[i*AW +: AW]) begin
                hit_reg    = '0;
                hit_reg[i] = 1'b1;
                hit_base   = REG_BASE[i*AW +: AW];
            end
        end
    end

    assign hit       = |hit_reg;
    assign mapped    = accept & hit;
    assign unmapped  = accept & ~hit;
    assign byte_wa   = (ROMAD - hit_base) >> LB;
    assign lane      = (LB == 0) ? '0 : ROMAD[LW-1:0];
    assign byte_mask = BPW'(1) << lane;

    // Packer: at most one word leaves per cycle; a leftover word under ROMCL low goes next cycle.
    always_comb begin
        push      = 1'b0;
        push_reg  = pk_reg_q;
        push_addr = pk_addr_q;
        push_data = pk_data_q;
        push_mask = pk_mask_q;
        pk_reg_d  = pk_reg_q;
        pk_addr_d = pk_addr_q;
        pk_data_d = pk_data_q;
        pk_mask_d = pk_mask_q;
        m_data    = pk_data_q;
        m_mask    = pk_mask_q;
        if (mapped) begin
            if (!pk_empty && (pk_reg_q != hit_reg || pk_addr_q != byte_wa)) begin
                push   = 1'b1;
                m_data = '0;
                m_mask = '0;
            end
            for (int k = 0; k < BPW; k++) begin
                if (int'(lane) == k) m_data[8*k +: 8] = ROMDT;
            end
            m_mask = m_mask | byte_mask;
            if (!push && (&m_mask || !ROMCL)) begin
                push      = 1'b1;
                push_reg  = hit_reg;
                push_addr = byte_wa;
                push_data = m_data;
                push_mask = m_mask;
                pk_reg_d  = '0;
                pk_addr_d = '0;
                pk_data_d = '0;
                pk_mask_d = '0;
            end else begin
                pk_reg_d  = hit_reg;
                pk_addr_d = byte_wa;
                pk_data_d = m_data;
                pk_mask_d = m_mask;
            end
        end else if (!ROMCL && !pk_empty) begin
            push      = 1'b1;
            pk_reg_d  = '0;
            pk_addr_d = '0;
            pk_data_d = '0;
            pk_mask_d = '0;
        end
    end

    assign WR_VALID = (cnt_q != '0);
    assign full     = (cnt_q == CW'(FIFO_D));
    assign pop      = WR_VALID & WR_READY;
    assign wr_en    = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rise) state_d = S_LOAD;
            S_LOAD:  if (fall) state_d = S_DRAIN;
            S_DRAIN: begin
                if (rise) state_d = S_LOAD;
                else if (pk_empty && cnt_q == '0) state_d = S_DONE;
            end
            S_DONE:  if (rise) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_load = (state_d == S_LOAD) && (state_q != S_LOAD);

    always_comb begin
        ovf_d = enter_load ? 1'b0 : ovf_q;
        if (drop) ovf_d = 1'b1;
        unm_d = enter_load ? 8'd0 : unm_q;
        if (unmapped) unm_d = sat_inc(unm_d);
    end

    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= S_IDLE;
            romcl_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unm_q     <= '0;
            pk_reg_q  <= '0;
            pk_addr_q <= '0;
            pk_data_q <= '0;
            pk_mask_q <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            romcl_q   <= ROMCL;
            ovf_q     <= ovf_d;
            unm_q     <= unm_d;
            pk_reg_q  <= pk_reg_d;
            pk_addr_q <= pk_addr_d;
            pk_data_q <= pk_data_d;
            pk_mask_q <= pk_mask_d;
            cnt_q     <= cnt_d;
            if (wr_en) wp_q <= wp_q + PW'(1);
            if (pop)   rp_q <= rp_q + PW'(1);
        end
    end

    always_ff @(posedge CLK48M) begin
        if (wr_en) begin
            f_reg_q[wp_q]  <= push_reg;
            f_addr_q[wp_q] <= push_addr;
            f_data_q[wp_q] <= push_data;
            f_mask_q[wp_q] <= push_mask;
        end
    end

    // Fields are gated by valid so every output reads zero while the FIFO is empty or in reset.
    assign WR_REG    = WR_VALID ? f_reg_q[rp_q]  : '0;
    assign WR_ADDR   = WR_VALID ? f_addr_q[rp_q] : '0;
    assign WR_DATA   = WR_VALID ? f_data_q[rp_q] : '0;
    assign WR_MASK   = WR_VALID ? f_mask_q[rp_q] : '0;
    assign BUSY      = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign DONE      = (state_q == S_DONE);
    assign OVF       = ovf_q;
    assign UNMAP_CNT = unm_q;
endmodule

// File: tb/tb_segasys1_romload_dispatch.sv
// Bench for segasys1_romload_dispatch: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_segasys1_romload_dispatch;
    logic        CLK48M = 1'b0;
    logic        RESETn = 1'b0;
    logic        ROMCL  = 1'b0;
    logic [24:0] ROMAD  = '0;
    logic [7:0]  ROMDT  = '0;
    logic        ROMEN  = 1'b0;
    logic        WR_READY = 1'b1;
    logic        WR_VALID;
    logic [1:0]  WR_REG;
    logic [24:0] WR_ADDR;
    logic [15:0] WR_DATA;
    logic [1:0]  WR_MASK;
    logic        BUSY, DONE, OVF;
    logic [7:0]  UNMAP_CNT;

    int n_checks = 0;
    int n_errors = 0;

    segasys1_romload_dispatch #(
        .NREG(2), .AW(25), .DW(16), .FIFO_D(4),
        .REG_BASE ({25'h08000, 25'h00000}),
        .REG_LIMIT({25'h0BFFF, 25'h07FFF})
    ) dut (
        .CLK48M(CLK48M), .RESETn(RESETn), .ROMCL(ROMCL), .ROMAD(ROMAD), .ROMDT(ROMDT),
        .ROMEN(ROMEN), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_REG(WR_REG),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_MASK(WR_MASK), .BUSY(BUSY), .DONE(DONE),
        .OVF(OVF), .UNMAP_CNT(UNMAP_CNT)
    );

    always #5 CLK48M = ~CLK48M;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK48M);
        #1;
    endtask

    task automatic drive(input logic cl, input logic [24:0] ad, input logic [7:0] dt,
                         input logic en, input logic rdy);
        ROMCL = cl; ROMAD = ad; ROMDT = dt; ROMEN = en; WR_READY = rdy;
    endtask

    typedef struct {
        logic cl; logic [24:0] ad; logic [7:0] dt; logic en; logic rdy;
        logic vld; logic [1:0] rg; logic [24:0] wa; logic [15:0] wd; logic [1:0] wm;
        logic busy; logic done;
    } vec_t;

    function automatic vec_t mk(logic cl, logic [24:0] ad, logic [7:0] dt, logic en, logic rdy,
                                logic vld, logic [1:0] rg, logic [24:0] wa, logic [15:0] wd,
                                logic [1:0] wm, logic busy, logic done);
        vec_t v;
        v.cl = cl; v.ad = ad; v.dt = dt; v.en = en; v.rdy = rdy;
        v.vld = vld; v.rg = rg; v.wa = wa; v.wd = wd; v.wm = wm; v.busy = busy; v.done = done;
        return v;
    endfunction

    // Reference model: one packer record plus a queue standing in for the word FIFO.
    typedef struct packed {
        logic [1:0] rg; logic [24:0] wa; logic [15:0] wd; logic [1:0] wm;
    } word_t;

    word_t mq[$];
    word_t m_pk;
    bit    m_pk_on;
    bit    m_ovf;
    int    m_unm;
    bit    m_prev_cl;

    task automatic model_reset();
        mq.delete();
        m_pk_on = 0; m_ovf = 0; m_unm = 0; m_prev_cl = 0;
    endtask

    task automatic model_cycle(input logic cl, input logic [24:0] ad, input logic [7:0] dt,
                               input logic en, input logic rdy);
        word_t       pushw;
        word_t       nb;
        bit          do_push;
        bit          acc;
        int          r;
        logic [24:0] base;
        do_push = 0;
        pushw   = '0;
        acc     = en && (cl || m_prev_cl);
        r       = -1;
        base    = '0;
        if (ad <= 25'h7FFF) begin r = 0; base = 25'h0; end
        else if (ad <= 25'hBFFF) begin r = 1; base = 25'h8000; end
        if (cl && !m_prev_cl) begin m_ovf = 0; m_unm = 0; end
        if (acc && r < 0 && m_unm < 255) m_unm++;
        if (acc && r >= 0) begin
            nb    = '0;
            nb.rg = 2'b01 << r;
            nb.wa = (ad - base) / 2;
            if (m_pk_on && (m_pk.rg != nb.rg || m_pk.wa != nb.wa)) begin
                pushw = m_pk; do_push = 1; m_pk_on = 0;
            end
            if (!m_pk_on) begin m_pk = nb; m_pk_on = 1; end
            if (ad[0]) m_pk.wd[15:8] = dt; else m_pk.wd[7:0] = dt;
            m_pk.wm[ad[0]] = 1'b1;
            if (!do_push && (m_pk.wm == 2'b11 || !cl)) begin
                pushw = m_pk; do_push = 1; m_pk_on = 0;
            end
        end else if (m_pk_on && !cl) begin
            pushw = m_pk; do_push = 1; m_pk_on = 0;
        end
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < 4) mq.push_back(pushw);
            else m_ovf = 1;
        end
        m_prev_cl = cl;
    endtask

    vec_t tbl[15];

    initial begin
        int k;
        logic        cl;
        logic [24:0] ad;
        int          sel;

        tbl[0]  = mk(1, 25'h0000, 8'h00, 0, 1, 0, 2'b00, 25'h0000, 16'h0000, 2'b00, 1, 0);
        tbl[1]  = mk(1, 25'h0000, 8'h12, 1, 1, 0, 2'b00, 25'h0000, 16'h0000, 2'b00, 1, 0);
        tbl[2]  = mk(1, 25'h0001, 8'h34, 1, 1, 1, 2'b01, 25'h0000, 16'h3412, 2'b11, 1, 0);
        tbl[3]  = mk(1, 25'h0000, 8'h00, 0, 1, 0, 2'b00, 25'h0000, 16'h0000, 2'b00, 1, 0);
        tbl[4]  = mk(1, 25'h8003, 8'hAA, 1, 1, 0, 2'b00, 25'h0000, 16'h0000, 2'b00, 1, 0);
        tbl[5]  = mk(1, 25'h8010, 8'h55, 1, 1, 1, 2'b10, 25'h0001, 16'hAA00, 2'b10, 1, 0);
        tbl[6]  = mk(0, 25'h0000, 8'h00, 0, 1, 1, 2'b10, 25'h0008, 16'h0055, 2'b01, 1, 0);
        tbl[7]  = mk(0, 25'h0000, 8'h00, 0, 1, 0, 2'b00, 25'h0000, 16'h0000, 2'b00, 1, 0);
        tbl[8]  = mk(0, 25'h0000, 8'h00, 0, 1, 0, 2'b00, 25'h0000, 16'h0000, 2'b00, 0, 1);
        tbl[9]  = mk(1, 25'h0000, 8'h00, 0, 1, 0, 2'b00, 25'h0000, 16'h0000, 2'b00, 1, 0);
        tbl[10] = mk(1, 25'h7FFF, 8'h11, 1, 1, 0, 2'b00, 25'h0000, 16'h0000, 2'b00, 1, 0);
        tbl[11] = mk(1, 25'h8000, 8'h22, 1, 1, 1, 2'b01, 25'h3FFF, 16'h1100, 2'b10, 1, 0);
        tbl[12] = mk(0, 25'h0000, 8'h00, 0, 1, 1, 2'b10, 25'h0000, 16'h0022, 2'b01, 1, 0);
        tbl[13] = mk(0, 25'h0000, 8'h00, 0, 1, 0, 2'b00, 25'h0000, 16'h0000, 2'b00, 1, 0);
        tbl[14] = mk(0, 25'h0000, 8'h00, 0, 1, 0, 2'b00, 25'h0000, 16'h0000, 2'b00, 0, 1);

        // Reset state
        repeat (3) step();
        chk("rst_valid", WR_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_unmap", UNMAP_CNT, 0);
        @(negedge CLK48M);
        RESETn = 1'b1;
        step();

        // Directed table: packing, region switch, ROMCL fall flush, DRAIN to DONE
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].cl, tbl[i].ad, tbl[i].dt, tbl[i].en, tbl[i].rdy);
            step();
            chk($sformatf("tbl%0d_valid", i), WR_VALID, tbl[i].vld);
            chk($sformatf("tbl%0d_busy", i), BUSY, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), DONE, tbl[i].done);
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_reg", i), WR_REG, tbl[i].rg);
                chk($sformatf("tbl%0d_addr", i), WR_ADDR, tbl[i].wa);
                chk($sformatf("tbl%0d_data", i), WR_DATA, tbl[i].wd);
                chk($sformatf("tbl%0d_mask", i), WR_MASK, tbl[i].wm);
            end
        end

        // Unmapped bytes: counter increments and saturates
        drive(1, 25'h0, 8'h0, 0, 1);
        step();
        drive(1, 25'hC000, 8'h5A, 1, 1);
        step();
        chk("unmap_one", UNMAP_CNT, 1);
        chk("unmap_nowrite", WR_VALID, 0);
        repeat (299) step();
        chk("unmap_sat", UNMAP_CNT, 255);
        drive(0, 25'h0, 8'h0, 0, 1);
        repeat (3) step();
        chk("unmap_done", DONE, 1);

        // Overflow: six words into a four-deep FIFO with the target stalled
        drive(1, 25'h0, 8'h0, 0, 0);
        step();
        chk("ovf_unmap_clr", UNMAP_CNT, 0);
        for (int i = 0; i < 12; i++) begin
            drive(1, 25'(i), 8'(i + 8'h40), 1, 0);
            step();
        end
        drive(1, 25'h0, 8'h0, 0, 0);
        step();
        chk("ovf_set", OVF, 1);
        chk("ovf_hold_valid", WR_VALID, 1);
        chk("ovf_hold_addr", WR_ADDR, 0);
        drive(0, 25'h0, 8'h0, 0, 1);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            if (WR_VALID) begin
                chk($sformatf("ovf_w%0d_addr", k), WR_ADDR, k);
                chk($sformatf("ovf_w%0d_data", k), WR_DATA,
                    {8'(2 * k + 1 + 8'h40), 8'(2 * k + 8'h40)});
                k++;
            end
            if (DONE) break;
            step();
        end
        chk("ovf_wcount", k, 4);
        chk("ovf_done", DONE, 1);
        chk("ovf_sticky", OVF, 1);

        // Asynchronous reset with words pending
        drive(1, 25'h0, 8'h0, 0, 0);
        step();
        chk("rst2_ovf_clr", OVF, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 25'(i), 8'(i), 1, 0);
            step();
        end
        drive(1, 25'h0, 8'h0, 0, 0);
        step();
        chk("rst2_pending", WR_VALID, 1);
        #2 RESETn = 1'b0;
        #1;
        chk("rst2_valid", WR_VALID, 0);
        chk("rst2_reg", WR_REG, 0);
        chk("rst2_addr", WR_ADDR, 0);
        chk("rst2_data", WR_DATA, 0);
        chk("rst2_mask", WR_MASK, 0);
        chk("rst2_busy", BUSY, 0);
        chk("rst2_done", DONE, 0);
        step();
        @(negedge CLK48M);
        RESETn   = 1'b1;
        WR_READY = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 6) ROMCL = 1'b0;
            step();
            if (WR_VALID) k++;
        end
        chk("rst2_no_write", k, 0);

        // Randomized traffic against the reference model
        drive(0, 25'h0, 8'h0, 0, 1);
        RESETn = 1'b0;
        step();
        step();
        @(negedge CLK48M);
        RESETn = 1'b1;
        step();
        model_reset();
        cl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_valid", WR_VALID, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("rnd_reg", WR_REG, mq[0].rg);
                chk("rnd_addr", WR_ADDR, mq[0].wa);
                chk("rnd_data", WR_DATA, mq[0].wd);
                chk("rnd_mask", WR_MASK, mq[0].wm);
            end
            chk("rnd_ovf", OVF, m_ovf);
            chk("rnd_unmap", UNMAP_CNT, m_unm);
            if ($urandom_range(0, 39) == 0) cl = ~cl;
            sel = $urandom_range(0, 3);
            case (sel)
                0: ad = 25'h7FFC;
                1: ad = 25'h8000;
                2: ad = 25'hBFFC;
                default: ad = 25'hC000;
            endcase
            ad = ad + 25'($urandom_range(0, 7));
            drive(cl, ad, 8'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
            model_cycle(ROMCL, ROMAD, ROMDT, ROMEN, WR_READY);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
